// File: rtl/game_pkg.sv
// Shared types and constants for the tic-tac-toe game controller.
package game_pkg;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;
  localparam logic [3:0] MAX_MOVES = 4'd9;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_A    = 2'b01,
    WIN_B    = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

endpackage

// File: rtl/cell_decode.sv
// Converts a 4-bit cell index into a one-hot board mask plus a range flag.
module cell_decode
  import game_pkg::*;
(
  input  logic [3:0]           move_pos_i,
  output logic [NUM_CELLS-1:0] onehot_o,
  output logic                 in_range_o
);

  always_comb begin
    in_range_o = (move_pos_i < 4'(NUM_CELLS));
    onehot_o   = '0;
    if (in_range_o) onehot_o = NUM_CELLS'(1) << move_pos_i;
  end

endmodule

// File: rtl/game_ctrl.sv
// Tic-tac-toe move sequencer: accepts moves, waits one cycle for the external
// winner detector to see the registered board, then declares win/draw or passes the turn.
//   state | meaning
//   PLAY  | waiting for a move from the player indicated by turn
//   CHECK | board updated, evaluating win_line and move count
//   DONE  | game finished, winner and win_line_q held until new_game
module game_ctrl
  import game_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_game,
  input  logic                 move_valid,
  input  logic [3:0]           move_pos,
  output logic                 move_ready,
  input  logic [NUM_LINES-1:0] win_line,
  output logic [NUM_CELLS-1:0] ain,
  output logic [NUM_CELLS-1:0] bin,
  output logic                 turn,
  output logic                 illegal,
  output logic                 game_over,
  output logic [1:0]           winner,
  output logic [NUM_LINES-1:0] win_line_q
);

  state_e                 state_q;
  logic [NUM_CELLS-1:0]   ain_q, bin_q;
  logic [3:0]             cnt_q;
  logic                   turn_q;
  logic                   illegal_q;
  logic                   game_over_q;
  winner_e                winner_q;
  logic [NUM_LINES-1:0]   win_cap_q;

  logic [NUM_CELLS-1:0]   cell_d;
  logic                   in_range_d;
  logic                   legal_d;

  cell_decode u_cell_decode (
    .move_pos_i (move_pos),
    .onehot_o   (cell_d),
    .in_range_o (in_range_d)
  );

  assign legal_d    = in_range_d && (((ain_q | bin_q) & cell_d) == '0);
  assign move_ready = (state_q == PLAY) && !new_game;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PLAY;
      ain_q       <= '0;
      bin_q       <= '0;
      cnt_q       <= '0;
      turn_q      <= 1'b0;
      illegal_q   <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= WIN_NONE;
      win_cap_q   <= '0;
    end else begin
      illegal_q <= 1'b0;
      if (new_game) begin
        state_q     <= PLAY;
        ain_q       <= '0;
        bin_q       <= '0;
        cnt_q       <= '0;
        turn_q      <= 1'b0;
        game_over_q <= 1'b0;
        winner_q    <= WIN_NONE;
        win_cap_q   <= '0;
      end else begin
        case (state_q)
          PLAY: begin
            if (move_valid) begin
              if (legal_d) begin
                if (turn_q) bin_q <= bin_q | cell_d;
                else        ain_q <= ain_q | cell_d;
                cnt_q   <= (cnt_q == MAX_MOVES) ? cnt_q : cnt_q + 4'd1;
                state_q <= CHECK;
              end else begin
                illegal_q <= 1'b1;
              end
            end
          end
          // A completed line wins even when the board is also full.
          CHECK: begin
            if (win_line != '0) begin
              state_q     <= DONE;
              game_over_q <= 1'b1;
              winner_q    <= turn_q ? WIN_B : WIN_A;
              win_cap_q   <= win_line;
            end else if (cnt_q == MAX_MOVES) begin
              state_q     <= DONE;
              game_over_q <= 1'b1;
              winner_q    <= WIN_DRAW;
              win_cap_q   <= '0;
            end else begin
              turn_q  <= ~turn_q;
              state_q <= PLAY;
            end
          end
          DONE: begin
            state_q <= DONE;
          end
          default: begin
            state_q <= PLAY;
          end
        endcase
      end
    end
  end

  assign ain        = ain_q;
  assign bin        = bin_q;
  assign turn       = turn_q;
  assign illegal    = illegal_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;
  assign win_line_q = win_cap_q;

endmodule
